// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and legality check for the decimal counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_ok(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register; step_o forwards the step when this digit sits at its wrap limit.
// Down counting is compiled in only with BCD_COUNTER_DOWN_EN.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       step_i,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic       up_i,
`endif
  output logic [3:0] digit_o,
  output logic       step_o
);

  bcd_digit_t digit_q, digit_d;
  bcd_digit_t inc_val;

  // Corrupted digits (10-15) recover to zero on their next step.
  always_comb begin
    inc_val = (digit_q == BCD_MAX || !bcd_ok(digit_q)) ? BCD_MIN : digit_q + 4'd1;
  end

`ifdef BCD_COUNTER_DOWN_EN
  bcd_digit_t dec_val;

  always_comb begin
    if (digit_q == BCD_MIN) begin
      dec_val = BCD_MAX;
    end else if (!bcd_ok(digit_q)) begin
      dec_val = BCD_MIN;
    end else begin
      dec_val = digit_q - 4'd1;
    end
  end

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = BCD_MIN;
    end else if (step_i) begin
      digit_d = up_i ? inc_val : dec_val;
    end
    step_o = step_i & (up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
  end
`else
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = BCD_MIN;
    end else if (step_i) begin
      digit_d = inc_val;
    end
    step_o = step_i & (digit_q == BCD_MAX);
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with built-in prescaler and registered tick/carry pulses.
// Define BCD_COUNTER_DOWN_EN to add the up port and down counting.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic                up,
`endif
  output logic [4*DIGITS-1:0] bcd,
  output logic                tick,
  output logic                carry
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] p_q, p_d;
  logic          tick_q, tick_d;
  logic          carry_q, carry_d;
  logic          step;
  // chain[k] is the step arriving at digit k; chain[DIGITS] means the whole vector wrapped.
  logic [DIGITS:0] chain;

  always_comb begin
    step    = en & ~clr & (p_q == PMAX);
    p_d     = p_q;
    if (clr) begin
      p_d = '0;
    end else if (en) begin
      p_d = (p_q == PMAX) ? '0 : p_q + PW'(1);
    end
    tick_d  = step;
    carry_d = chain[DIGITS];
  end

  assign chain[0] = step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (clr),
      .step_i  (chain[g]),
`ifdef BCD_COUNTER_DOWN_EN
      .up_i    (up),
`endif
      .digit_o (bcd[4*g +: 4]),
      .step_o  (chain[g+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench: two counters (CLK_DIV=4 and CLK_DIV=1) against an integer reference model.
module tb_bcd_counter;

  localparam int MOD = 10000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, clr_a = 1'b0, up_a = 1'b1;
  logic        en_b = 1'b0, clr_b = 1'b0, up_b = 1'b1;
  logic [15:0] bcd_a, bcd_b;
  logic        tick_a, carry_a, tick_b, carry_b;

  int checks = 0;
  int failures = 0;

  // Reference state: prescale position and the count as a plain integer.
  int pa = 0, va = 0, pb = 0, vb = 0;
  bit ta = 0, ca = 0, tb2 = 0, cb = 0;

  always #5 clk = ~clk;

  bcd_counter #(.CLK_DIV(4), .DIGITS(4)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .en    (en_a),
    .clr   (clr_a),
`ifdef BCD_COUNTER_DOWN_EN
    .up    (up_a),
`endif
    .bcd   (bcd_a),
    .tick  (tick_a),
    .carry (carry_a)
  );

  bcd_counter #(.CLK_DIV(1), .DIGITS(4)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .en    (en_b),
    .clr   (clr_b),
`ifdef BCD_COUNTER_DOWN_EN
    .up    (up_b),
`endif
    .bcd   (bcd_b),
    .tick  (tick_b),
    .carry (carry_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int cdiv, input bit e, input bit c, input bit u,
                            inout int p, inout int v, output bit t, output bit cy);
    t  = 0;
    cy = 0;
    if (c) begin
      p = 0;
      v = 0;
    end else if (e) begin
      if (p == cdiv - 1) begin
        p = 0;
        t = 1;
        if (u) begin
          cy = (v == MOD - 1);
          v  = (v + 1) % MOD;
        end else begin
          cy = (v == 0);
          v  = (v + MOD - 1) % MOD;
        end
      end else begin
        p++;
      end
    end
  endtask

  function automatic bit eff_up(input logic u);
`ifdef BCD_COUNTER_DOWN_EN
    return u;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: models update on the edge, outputs compared #1 later.
  task automatic run_cycle();
    @(posedge clk);
    model_step(4, en_a, clr_a, eff_up(up_a), pa, va, ta, ca);
    model_step(1, en_b, clr_b, eff_up(up_b), pb, vb, tb2, cb);
    #1;
    check_eq("a_bcd", {16'h0, bcd_a}, to_bcd(va));
    check_eq("a_tick", {31'h0, tick_a}, {31'h0, ta});
    check_eq("a_carry", {31'h0, carry_a}, {31'h0, ca});
    check_eq("b_bcd", {16'h0, bcd_b}, to_bcd(vb));
    check_eq("b_tick", {31'h0, tick_b}, {31'h0, tb2});
    check_eq("b_carry", {31'h0, carry_b}, {31'h0, cb});
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pa = 0; va = 0; pb = 0; vb = 0;
    #1;
    check_eq("rst_a_bcd", {16'h0, bcd_a}, 32'h0);
    check_eq("rst_a_tick", {31'h0, tick_a}, 32'h0);
    check_eq("rst_a_carry", {31'h0, carry_a}, 32'h0);
    check_eq("rst_b_bcd", {16'h0, bcd_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    en_a = 0; clr_a = 0; en_b = 0; clr_b = 0; up_a = 1; up_b = 1;
    do_reset();

    // Enabled 16 cycles at CLK_DIV=4: four steps, ticks on every 4th cycle.
    en_a = 1;
    for (int i = 1; i <= 16; i++) begin
      run_cycle();
      check_eq("t1_tick_pattern", {31'h0, tick_a}, {31'h0, (i % 4) == 0});
    end
    check_eq("t1_bcd", {16'h0, bcd_a}, 32'h0004);

    // Enable gap mid-prescale: prescaler resumes rather than restarts.
    do_reset();
    en_a = 1; run_n(2);
    en_a = 0; run_n(10);
    check_eq("t3_hold", {16'h0, bcd_a}, 32'h0000);
    en_a = 1; run_n(2);
    check_eq("t3_bcd", {16'h0, bcd_a}, 32'h0001);
    check_eq("t3_tick", {31'h0, tick_a}, 32'h1);

    // Clear on the terminal prescale cycle at 0x0123.
    do_reset();
    en_a = 1; run_n(123 * 4);
    check_eq("t4_pre", {16'h0, bcd_a}, 32'h0123);
    run_n(3);
    clr_a = 1; run_cycle();
    check_eq("t4_clr_bcd", {16'h0, bcd_a}, 32'h0);
    check_eq("t4_clr_tick", {31'h0, tick_a}, 32'h0);
    clr_a = 0; run_n(3);
    check_eq("t4_no_step", {16'h0, bcd_a}, 32'h0);
    run_cycle();
    check_eq("t4_step", {16'h0, bcd_a}, 32'h0001);
    en_a = 0;

    // CLK_DIV=1 full wrap.
    do_reset();
    en_b = 1; run_n(9998);
    check_eq("t2_9998", {16'h0, bcd_b}, 32'h9998);
    check_eq("t2_tick_cont", {31'h0, tick_b}, 32'h1);
    run_cycle();
    check_eq("t2_9999", {16'h0, bcd_b}, 32'h9999);
    check_eq("t2_nocarry", {31'h0, carry_b}, 32'h0);
    run_cycle();
    check_eq("t2_wrap", {16'h0, bcd_b}, 32'h0000);
    check_eq("t2_carry", {31'h0, carry_b}, 32'h1);
    run_cycle();
    check_eq("t2_carry_drop", {31'h0, carry_b}, 32'h0);
    en_b = 0;

`ifdef BCD_COUNTER_DOWN_EN
    // Down count from reset, then reverse direction.
    up_b = 0;
    do_reset();
    en_b = 1; run_cycle();
    check_eq("t5_9999", {16'h0, bcd_b}, 32'h9999);
    check_eq("t5_carry", {31'h0, carry_b}, 32'h1);
    run_n(2);
    check_eq("t5_9997", {16'h0, bcd_b}, 32'h9997);
    up_b = 1; run_cycle();
    check_eq("t5_up", {16'h0, bcd_b}, 32'h9998);
    en_b = 0;
`endif

    // Async reset mid-operation at 0x0057.
    do_reset();
    en_a = 1; run_n(57 * 4);
    check_eq("t6_pre", {16'h0, bcd_a}, 32'h0057);
    en_a = 0;
    do_reset();

    // Randomized traffic on both counters.
    for (int i = 0; i < 4000; i++) begin
      en_a  = ($urandom_range(0, 3) != 0);
      clr_a = ($urandom_range(0, 63) == 0);
      en_b  = ($urandom_range(0, 7) != 0);
      clr_b = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 15) == 0) up_a = ~up_a;
      if ($urandom_range(0, 31) == 0) up_b = ~up_b;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
